// File: rtl/puzzle_pkg.sv
// Shared 8-puzzle definitions: board layout, direction codes, replay states
// and cell/header accessors used by the replay engine and the register file.
package puzzle_pkg;
    localparam int BOARD_W = 40;
    localparam int ORD_W   = 34;

    localparam logic [BOARD_W-1:0] IDEAL = 40'h8123456780;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT,
        ST_WAIT,
        ST_APPLY,
        ST_DONE,
        ST_ERR
    } state_e;

    function automatic logic [3:0] blank_idx(input logic [BOARD_W-1:0] b);
        return b[39:36];
    endfunction

    // Cell 0 is the most significant nibble below the header; i must be 0..8.
    function automatic logic [3:0] cell_get(input logic [BOARD_W-1:0] b, input logic [3:0] i);
        logic [5:0] sh;
        sh = {4'd8 - i, 2'b00};
        return 4'(b[35:0] >> sh);
    endfunction

    function automatic logic [BOARD_W-1:0] cell_set(input logic [BOARD_W-1:0] b,
                                                    input logic [3:0] i,
                                                    input logic [3:0] v);
        logic [5:0]  sh;
        logic [35:0] m;
        logic [35:0] cells;
        sh    = {4'd8 - i, 2'b00};
        m     = 36'hF << sh;
        cells = (b[35:0] & ~m) | (36'(v) << sh);
        return {b[39:36], cells};
    endfunction
endpackage

// File: rtl/puzzle_replay_if.sv
// Board stream from the replay engine to the display side (valid/ready).
interface puzzle_replay_if;
    import puzzle_pkg::*;

    logic [BOARD_W-1:0] out_board;
    logic [3:0]         out_step;
    logic               out_valid;
    logic               out_ready;

    modport master (output out_board, output out_step, output out_valid, input out_ready);
    modport slave  (input out_board, input out_step, input out_valid, output out_ready);
endinterface

// File: rtl/board_slide.sv
// Combinational single move: slides the blank one step in dir, flags moves
// that would leave the 3x3 grid or start from a corrupt blank index.
module board_slide
    import puzzle_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    input  logic [1:0]         dir,
    output logic [BOARD_W-1:0] next_board,
    output logic               illegal
);
    logic [3:0] idx;
    logic [3:0] nidx;
    logic [3:0] tile;

    always_comb begin
        idx        = blank_idx(board);
        nidx       = idx;
        tile       = 4'd0;
        illegal    = (idx > 4'd8);
        next_board = board;
        case (dir)
            DIR_UP:    begin illegal = illegal | (idx < 4'd3);          nidx = idx - 4'd3; end
            DIR_DOWN:  begin illegal = illegal | (idx > 4'd5);          nidx = idx + 4'd3; end
            DIR_LEFT:  begin illegal = illegal | ((idx % 4'd3) == 4'd0); nidx = idx - 4'd1; end
            DIR_RIGHT: begin illegal = illegal | ((idx % 4'd3) == 4'd2); nidx = idx + 4'd1; end
        endcase
        if (!illegal) begin
            tile              = cell_get(board, nidx);
            next_board        = cell_set(cell_set(board, nidx, 4'd0), idx, tile);
            next_board[39:36] = nidx;
        end
    end
endmodule

// File: rtl/puzzle_replay.sv
// Replays a solved move sequence one board per handshake, pacing the stream
// and flagging sequences that are illegal or do not finish on the ideal board.
module puzzle_replay
    import puzzle_pkg::*;
#(
    parameter int PACE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BOARD_W-1:0] init_board,
    input  logic [ORD_W-1:0]   ord,
    input  logic               comp,
    puzzle_replay_if.master    dsp,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int CW = (PACE > 1) ? $clog2(PACE + 1) : 1;

    state_e             state_q, state_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic [ORD_W-1:0]   ord_q,   ord_d;
    logic [3:0]         step_q,  step_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    logic               done_q,  done_d;
    logic               err_q,   err_d;

    logic [1:0]         mv_dir;
    logic [BOARD_W-1:0] slid;
    logic               mv_bad;
    logic [3:0]         depth;

    assign depth  = ord_q[33:30];
    assign mv_dir = ord_q[{step_q, 1'b0} +: 2];

    board_slide u_slide (
        .board      (board_q),
        .dir        (mv_dir),
        .next_board (slid),
        .illegal    (mv_bad)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            board_q <= '0;
            ord_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            ord_q   <= ord_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        ord_d   = ord_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    if (!comp) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        board_d = init_board;
                        ord_d   = ord;
                        step_d  = 4'd0;
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (dsp.out_ready) begin
                    if (step_q == depth) begin
                        if (board_q == IDEAL) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(PACE);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_APPLY;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_APPLY: begin
                // An illegal move leaves the last emitted board on the bus.
                if (mv_bad) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    board_d = slid;
                    step_d  = step_q + 4'd1;
                    state_d = ST_EMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dsp.out_valid = (state_q == ST_EMIT);
    assign dsp.out_board = board_q;
    assign dsp.out_step  = step_q;
    assign busy          = (state_q == ST_EMIT) || (state_q == ST_WAIT) || (state_q == ST_APPLY);
    assign done          = done_q;
    assign err           = err_q;
endmodule

// File: doc/puzzle_replay.md
# puzzle_replay

Replays a solved 8-puzzle move sequence and streams every intermediate board to the display side. Sits downstream of the solver register file: it takes the stored initial board, the depth/direction word and the solved flag, re-applies the moves one at a time, and presents each board over a valid/ready handshake, paced for human viewing. It also checks that the replayed sequence actually ends on the ideal board.

## Interface
Parameters:
- PACE, 0 — idle cycles inserted after each accepted board before the next move is applied.

Ports:
- Reset `rst_n` is synchronous and active-low; the clock is `clk`.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that begins a replay
- init_board  in  40  start board; [39:36] blank index 0–8, cells 0..8 in [35:32]..[3:0]
- ord  in  34  [33:30] depth 0–15; move k in [2k+1:2k]
- comp  in  1  solver-solved flag
- out_board  out  40  current board, same format as init_board
- out_step  out  4  index of the board shown; 0 is the initial board
- out_valid  out  1  board available
- out_ready  in  1  display accepts the board
- busy  out  1  replay in progress
- done  out  1  sticky; replay finished on the ideal board
- err  out  1  sticky; illegal move, final board mismatch, or start with comp=0

## Operation
- Direction codes are blank-motion codes: 00 up (idx−3), 01 down (idx+3), 10 left (idx−1), 11 right (idx+1).
- A move is illegal under these conditions:
  - up when idx<3
  - down when idx>5
  - left when idx%3==0
  - right when idx%3==2
- Applying a move:
  - the cell at new idx takes value 0
  - the cell at old idx takes the tile previously at new idx
  - the header is set to new idx
- States are IDLE, EMIT, WAIT, APPLY, DONE, ERR.
- IDLE/DONE/ERR, start=1:
  - Clears done and err.
  - If comp=0, goes to ERR (err=1).
  - Otherwise captures init_board into out_board and ord into an internal register, sets out_step=0, and goes to EMIT.
- start is ignored in EMIT, WAIT and APPLY.
- EMIT:
  - out_valid=1.
  - On out_valid & out_ready:
    - if out_step==depth, compare out_board with 40'h8123456780 and go to DONE (done=1) on a match, or ERR (err=1) on a mismatch;
    - otherwise go to WAIT with the pace counter set to PACE.
- WAIT: the counter decrements; go to APPLY when it reaches 0. When PACE=0, WAIT lasts 1 cycle.
- APPLY:
  - Decode move out_step.
  - If illegal, go to ERR; out_board keeps the last emitted board.
  - If legal, register the new board, increment out_step, and go to EMIT.
- busy=1 in EMIT, WAIT and APPLY.

## Timing
- Reset values: all outputs 0, state IDLE, internal registers 0. Reset mid-replay aborts immediately with no further beats.
- start at edge t → out_valid=1 at cycle t+1.
- Handshake at edge h → the next out_valid rises at h+PACE+2 (WAIT then APPLY, each registered).
- out_board and out_step hold stable while out_valid=1 and out_ready=0.
- A beat occurs only when out_valid and out_ready are both sampled high at a rising edge.
- done/err assert on the cycle after the terminal event and hold until the next accepted start or reset.
- out_valid is never asserted in DONE or ERR.
- For depth d, exactly d+1 beats occur before DONE.

## Structure
- Shared package `puzzle_pkg` holds:
  - BOARD_W=40, ORD_W=34
  - the IDEAL constant
  - direction code constants
  - the replay state enum
  - cell/header field-extract helpers, which the register file uses as well.
- Sub-module `board_slide` is purely combinational: board[39:0] and dir[1:0] in; next_board[39:0] and illegal out.

## Test plan
- Nominal replay, PACE=0, out_ready=1:
  - Stimulus: init 40'h4123405786, ord 34'h080000007 (right, then down).
  - Required beats: 0x4123405786/step0, 0x5123450786/step1, 0x8123456780/step2.
  - Then done=1, err=0.
- Illegal move:
  - Stimulus: same init, ord 34'h08000000A (left, left).
  - Required beats: 0x4123405786, then 0x3123045786.
  - Then err=1 with no third beat.
- Backpressure:
  - Stimulus: nominal replay, PACE=3, out_ready held low 5 cycles on each beat.
  - Required: board and step stable while stalled; next valid exactly 5 cycles after each handshake.
- Depth 0:
  - Stimulus: init 40'h8123456780, ord 0.
  - Required: a single beat, then done.
  - Repeat with init 40'h4123405786 and ord 0: a single beat, then err.
- start with comp=0:
  - Required: err=1 one cycle later, out_valid never asserted.
- Reset and re-arm:
  - rst_n low during WAIT → all outputs 0.
  - A subsequent start then replays normally from step 0.
  - A start during EMIT is ignored.
